// File: rtl/error_sampler_fp.sv
//==============================================================================
// Module   : error_sampler_fp
// Purpose  : Periodically reads a 12-bit serial ADC, forms the control error
//            (ref_code - adc_code) and publishes it as an IEEE-754 double with a
//            4-cycle e0ready strobe for a downstream compensator.
// Ports    : clk_50              - single clock, rising edge
//            iRST                - asynchronous active-high reset
//            ref_code[11:0]      - setpoint in ADC counts
//            adc_dout            - serial data from the ADC
//            adc_cs_n/sclk/din   - serial ADC frame signals
//            adc_code[11:0]      - last ADC result
//            e0[63:0]            - double of (ref_code - adc_code)
//            e0ready             - sample strobe, high 4 cycles
//            overrun             - sticky missed-sample flag
// Options  : ADC_AVG4_EN - when defined, each sample averages 4 back-to-back
//            ADC frames (14-bit sum, result = sum >> 2).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module error_sampler_fp #(
  parameter int         CLK_DIV       = 2,
  parameter int         SAMPLE_PERIOD = 400,
  parameter logic [2:0] CHANNEL       = 3'd0
) (
  input  logic        clk_50,
  input  logic        iRST,
  input  logic [11:0] ref_code,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  output logic [11:0] adc_code,
  output logic [63:0] e0,
  output logic        e0ready,
  output logic        overrun
);

  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, FRAME, CONVERT, PUBLISH} state_t;
  state_t state, state_nx;

  logic [TW-1:0] timer;
  logic [DW-1:0] div_cnt;
  logic [4:0]    edge_cnt;   // SCLK toggles completed in this frame
  logic [10:0]   shift_in;
  logic [11:0]   ref_lat, code_lat;
  logic [3:0]    step;       // cycle index inside CONVERT / PUBLISH
  logic          sign;
  logic [11:0]   mag;
  logic [3:0]    shifts;
  logic          ready_nx;

  logic          sample_tick, sclk_toggle, frame_end, last_frame;
  logic [11:0]   frame_code, result_code, mag_init;
  logic [12:0]   err;

  assign sample_tick = (timer == '0);
  assign sclk_toggle = (state == FRAME) && !adc_cs_n && (div_cnt == DIV_LAST);
  // The 32nd toggle is the 16th rising edge; cs_n rises on the same cycle.
  assign frame_end   = sclk_toggle && (edge_cnt == 5'd31);
  assign frame_code  = {shift_in, adc_dout};

`ifdef ADC_AVG4_EN
  logic [1:0]  frame_idx;
  logic [13:0] acc, avg_sum;
  assign last_frame  = (frame_idx == 2'd3);
  assign avg_sum     = acc + {2'b00, frame_code};
  assign result_code = avg_sum[13:2];
`else
  assign last_frame  = 1'b1;
  assign result_code = frame_code;
`endif

  assign err      = {1'b0, ref_lat} - {1'b0, code_lat};
  assign mag_init = 12'(err[12] ? (13'd0 - err) : err);

  // State register
  always_ff @(posedge clk_50 or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state and strobe decode
  always_comb begin
    state_nx = state;
    ready_nx = 1'b0;
    case (state)
      IDLE:    if (sample_tick) state_nx = FRAME;
      FRAME:   if (frame_end && last_frame) state_nx = CONVERT;
      CONVERT: if (step == 4'd11) state_nx = PUBLISH;
      PUBLISH: begin
        // step 0 writes e0; steps 1..4 hold e0ready; step 5 returns to IDLE
        ready_nx = (step >= 4'd1) && (step <= 4'd4);
        if (step == 4'd5) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk_50 or posedge iRST) begin
    if (iRST) begin
      timer    <= '0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      shift_in <= '0;
      ref_lat  <= '0;
      code_lat <= '0;
      step     <= '0;
      sign     <= 1'b0;
      mag      <= '0;
      shifts   <= '0;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b1;
      adc_din  <= 1'b0;
      adc_code <= '0;
      e0       <= '0;
      e0ready  <= 1'b0;
      overrun  <= 1'b0;
`ifdef ADC_AVG4_EN
      frame_idx <= '0;
      acc       <= '0;
`endif
    end else begin
      timer   <= (timer == TIMER_LAST) ? '0 : timer + 1'b1;
      e0ready <= ready_nx;
      if (sample_tick && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (sample_tick) begin
            adc_cs_n <= 1'b0;
            adc_sclk <= 1'b1;
            adc_din  <= 1'b0;
            div_cnt  <= '0;
            edge_cnt <= '0;
`ifdef ADC_AVG4_EN
            frame_idx <= '0;
            acc       <= '0;
`endif
          end
        end

        FRAME: begin
          if (adc_cs_n) begin
            // One-cycle cs_n high gap between averaged frames
            adc_cs_n <= 1'b0;
            div_cnt  <= '0;
            edge_cnt <= '0;
          end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            if (sclk_toggle) begin
              adc_sclk <= ~adc_sclk;
              edge_cnt <= edge_cnt + 1'b1;
              if (!edge_cnt[0]) begin
                // Falling edge n = edge_cnt/2 + 1; channel on falls 3..5
                case (edge_cnt)
                  5'd4:    adc_din <= CHANNEL[2];
                  5'd6:    adc_din <= CHANNEL[1];
                  5'd8:    adc_din <= CHANNEL[0];
                  default: adc_din <= 1'b0;
                endcase
              end else begin
                // Rising edge: 16 bits shift through, the last 12 remain
                shift_in <= frame_code[10:0];
              end
              if (frame_end) begin
                adc_cs_n <= 1'b1;
`ifdef ADC_AVG4_EN
                if (last_frame) begin
                  code_lat <= result_code;
                  ref_lat  <= ref_code;
                  step     <= '0;
                end else begin
                  acc       <= avg_sum;
                  frame_idx <= frame_idx + 1'b1;
                end
`else
                code_lat <= result_code;
                ref_lat  <= ref_code;
                step     <= '0;
`endif
              end
            end
          end
        end

        CONVERT: begin
          step <= (step == 4'd11) ? 4'd0 : step + 1'b1;
          if (step == 4'd0) begin
            sign   <= err[12];
            mag    <= mag_init;
            shifts <= '0;
          end else if (!mag[11]) begin
            // Eleven shift slots cover the worst case (|err| = 1)
            mag    <= {mag[10:0], 1'b0};
            shifts <= shifts + 1'b1;
          end
        end

        PUBLISH: begin
          step <= (step == 4'd5) ? 4'd0 : step + 1'b1;
          if (step == 4'd0) begin
            adc_code <= code_lat;
            if (mag == 12'd0) e0 <= 64'd0;
            else e0 <= {sign, 11'd1034 - {7'd0, shifts}, mag[10:0], 41'd0};
          end
        end

        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_error_sampler_fp.sv
//==============================================================================
// Module   : tb_error_sampler_fp
// Purpose  : Directed self-checking bench for error_sampler_fp with a serial
//            ADC model, frame/strobe monitors and a second overrun instance.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_error_sampler_fp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] ref_code = 12'd0;
  logic        adc_dout = 1'b0;
  logic [15:0] adc_word = 16'd0;

  logic        adc_cs_n, adc_sclk, adc_din, e0ready, overrun;
  logic [11:0] adc_code;
  logic [63:0] e0;

  logic [11:0] ref2 = 12'd0;
  logic        dout2 = 1'b0;
  logic        cs_n2, sclk2, din2, rdy2, ovr2;
  logic [11:0] code2;
  logic [63:0] e0_2;

  error_sampler_fp #(.CLK_DIV(2), .SAMPLE_PERIOD(400), .CHANNEL(3'd5)) dut (
    .clk_50(clk), .iRST(rst), .ref_code(ref_code), .adc_dout(adc_dout),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din),
    .adc_code(adc_code), .e0(e0), .e0ready(e0ready), .overrun(overrun)
  );

  error_sampler_fp #(.CLK_DIV(2), .SAMPLE_PERIOD(50), .CHANNEL(3'd0)) dut_ovr (
    .clk_50(clk), .iRST(rst), .ref_code(ref2), .adc_dout(dout2),
    .adc_cs_n(cs_n2), .adc_sclk(sclk2), .adc_din(din2),
    .adc_code(code2), .e0(e0_2), .e0ready(rdy2), .overrun(ovr2)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ADC model: bit (16-n) of adc_word is presented after SCLK falling edge n
  int fall_cnt = 0, rise_cnt = 0, pulses_last = 0;
  int cs_rise_cnt = 0, cs_rise_cyc = 0;
  logic [2:0] din_cap = 3'd0;
  always @(negedge adc_cs_n) begin fall_cnt = 0; rise_cnt = 0; end
  always @(negedge adc_sclk) if (!adc_cs_n && fall_cnt < 16) begin
    adc_dout = adc_word[15 - fall_cnt];
    fall_cnt++;
  end
  always @(posedge adc_sclk) begin
    rise_cnt++;
    if (rise_cnt >= 3 && rise_cnt <= 5) din_cap[5 - rise_cnt] = adc_din;
  end
  always @(posedge adc_cs_n) begin
    pulses_last = fall_cnt;
    cs_rise_cnt++;
    cs_rise_cyc = cyc;
  end

  int rdy_cnt = 0, rdy_cyc = 0, rdy_prev = 0, rdy_width = 0, e0_hi_changes = 0;
  always @(posedge e0ready) begin rdy_prev = rdy_cyc; rdy_cyc = cyc; rdy_cnt++; end
  always @(negedge e0ready) rdy_width = cyc - rdy_cyc;
  always @(e0) if (e0ready === 1'b1) e0_hi_changes++;

  int rdy2_cyc = 0, rdy2_prev = 0, cs2_fall = 0, cs2_low = 0;
  always @(posedge rdy2) begin rdy2_prev = rdy2_cyc; rdy2_cyc = cyc; end
  always @(negedge cs_n2) cs2_fall = cyc;
  always @(posedge cs_n2) cs2_low = cyc - cs2_fall;

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_sample(input string tag, input logic [11:0] r, input logic [11:0] code,
                            input logic [63:0] exp_e0, input bit chk_period);
    int n_cs, n_rdy;
    bit ok;
    n_cs  = cs_rise_cnt;
    n_rdy = rdy_cnt;
    ref_code = r;
    adc_word = {4'b1010, code};  // leading junk nibble must be discarded
    for (int i = 0; i < 1000 && cs_rise_cnt == n_cs; i++) @(posedge clk);
    ok = (cs_rise_cnt != n_cs);
    check({tag, "_cs_wait"}, 64'(ok), 64'd1);
    #1 ref_code = ~r;            // too late to affect this sample
    for (int i = 0; i < 100 && rdy_cnt == n_rdy; i++) @(posedge clk);
    ok = (rdy_cnt != n_rdy);
    check({tag, "_rdy_wait"}, 64'(ok), 64'd1);
    @(negedge clk);
    check({tag, "_e0"}, e0, exp_e0);
    check({tag, "_code"}, 64'(adc_code), 64'(code));
    check({tag, "_latency"}, 64'(rdy_cyc - cs_rise_cyc), 64'd14);
    check({tag, "_pulses"}, 64'(pulses_last), 64'd16);
    check({tag, "_din"}, 64'(din_cap), 64'd5);
    for (int i = 0; i < 20 && e0ready; i++) @(negedge clk);
    check({tag, "_width"}, 64'(rdy_width), 64'd4);
    if (chk_period) check({tag, "_period"}, 64'(rdy_cyc - rdy_prev), 64'd400);
  endtask

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 64'(adc_cs_n), 64'd1);
    check("rst_sclk", 64'(adc_sclk), 64'd1);
    check("rst_din", 64'(adc_din), 64'd0);
    check("rst_e0", e0, 64'd0);
    check("rst_code", 64'(adc_code), 64'd0);
    check("rst_rdy", 64'(e0ready), 64'd0);
    check("rst_ovr", 64'(overrun), 64'd0);

    ref_code = 12'd2048;
    adc_word = {4'b1010, 12'd1024};
    rst = 1'b0;
    @(negedge clk);
    check("first_edge_cs", 64'(adc_cs_n), 64'd0);

    run_sample("s1", 12'd2048, 12'd1024, 64'h4090000000000000, 1'b0);
    run_sample("s2", 12'd1000, 12'd1000, 64'h0000000000000000, 1'b1);
    run_sample("s3", 12'd0,    12'd4095, 64'hC0AFFE0000000000, 1'b1);
    run_sample("s4", 12'd5,    12'd10,   64'hC014000000000000, 1'b1);
    run_sample("s5", 12'd3000, 12'd1,    64'h40A76E0000000000, 1'b1);
    run_sample("s6", 12'd1,    12'd0,    64'h3FF0000000000000, 1'b1);
    run_sample("s7", 12'd4095, 12'd0,    64'h40AFFE0000000000, 1'b1);
    check("ovr_main", 64'(overrun), 64'd0);
    check("ovr_dut2", 64'(ovr2), 64'd1);

    // Reset in the middle of a frame (8th SCLK pulse)
    for (int i = 0; i < 1000 && adc_cs_n; i++) @(posedge clk);
    for (int i = 0; i < 100 && rise_cnt < 8; i++) @(posedge clk);
    ok = (!adc_cs_n && rise_cnt == 8);
    check("mid_wait", 64'(ok), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_cs_n", 64'(adc_cs_n), 64'd1);
    check("mid_sclk", 64'(adc_sclk), 64'd1);
    check("mid_e0", e0, 64'd0);
    check("mid_code", 64'(adc_code), 64'd0);
    check("mid_ovr2", 64'(ovr2), 64'd0);
    repeat (3) @(negedge clk);
    ref_code = 12'd2048;
    adc_word = {4'b1010, 12'd1024};
    rst = 1'b0;
    @(negedge clk);
    check("restart_cs", 64'(adc_cs_n), 64'd0);
    run_sample("post", 12'd2048, 12'd1024, 64'h4090000000000000, 1'b0);

    repeat (250) @(negedge clk);
    check("ovr2_flag", 64'(ovr2), 64'd1);
    check("ovr2_period", 64'(rdy2_cyc - rdy2_prev), 64'd100);
    check("ovr2_cs_low", 64'(cs2_low), 64'd64);
    check("e0_stable", 64'(e0_hi_changes), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/error_sampler_fp.md
ERROR_SAMPLER_FP -- requirements
Module: error_sampler_fp

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 2: clk_50 cycles per SCLK half-period (12.5 MHz SCLK).
REQ-002 SHALL provide parameter SAMPLE_PERIOD, default 400: clk_50 cycles between sample starts (125 kHz).
REQ-003 SHALL provide parameter CHANNEL, default 3'd0: ADC input channel address.
REQ-004 SHALL have port clk_50  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port iRST  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port ref_code  input  12: setpoint in ADC counts.
REQ-007 SHALL have port adc_dout  input  1: serial data from the ADC.
REQ-008 SHALL have ports adc_cs_n, adc_sclk, adc_din  output  1 each: serial ADC frame signals.
REQ-009 SHALL have port adc_code  output  12: last ADC result.
REQ-010 SHALL have port e0  output  64: IEEE-754 double of (ref_code - adc_code).
REQ-011 SHALL have port e0ready  output  1: sample strobe consumed by the compensator on its rising edge.
REQ-012 SHALL have port overrun  output  1: sticky missed-sample flag.

Function
REQ-013 SHALL run free-running timer 0..SAMPLE_PERIOD-1; a sample starts when timer==0 and the FSM is IDLE.
REQ-014 SHALL implement FSM IDLE -> FRAME -> CONVERT -> PUBLISH -> IDLE.
REQ-015 FRAME SHALL drive adc_cs_n low for exactly 16 SCLK periods; SCLK idles high and toggles every CLK_DIV cycles.
REQ-016 SHALL shift CHANNEL MSB-first onto adc_din on SCLK falling edges 3-5, otherwise 0.
REQ-017 SHALL sample adc_dout on SCLK rising edges; discard the first 4 bits; keep the next 12 MSB-first as adc_code.
REQ-018 SHALL latch ref_code on the cycle adc_cs_n deasserts; later ref_code changes do not affect that sample.
REQ-019 CONVERT SHALL form err = ref_code - adc_code as 13-bit signed (range -4095..+4095).
REQ-020 CONVERT SHALL last exactly 12 cycles regardless of value; normalization is by iterative left shift.
REQ-021 Conversion SHALL be exact: sign = err<0; magnitude normalized to bit 11 after k shifts; exponent = 1034 - k; fraction = the 11 bits below the leading one, MSB-aligned in the 52-bit field, rest 0.
REQ-022 err==0 SHALL produce e0 = 64'h0 (positive zero).
REQ-023 PUBLISH SHALL update e0 and adc_code; e0ready SHALL rise on the following cycle and stay high exactly 4 cycles.
REQ-024 e0 SHALL hold stable from its update until the next PUBLISH; e0 never changes while e0ready is high.
REQ-025 Latency SHALL be fixed: adc_cs_n rising to e0 update = 13 cycles; e0ready rises at 14.
REQ-026 If timer==0 while FSM not IDLE, that sample SHALL be skipped and overrun set until reset.
REQ-027 SAMPLE_PERIOD below frame + 18 cycles SHALL cause every other sample to be skipped, with overrun set; no frame is truncated.

Reset
REQ-028 iRST SHALL take effect asynchronously, including mid-frame: adc_cs_n=1, adc_sclk=1, adc_din=0, adc_code=0, e0=0, e0ready=0, overrun=0, timer=0, FSM=IDLE.
REQ-029 After iRST deasserts, the first frame SHALL start on the first clk_50 edge.

Configuration
REQ-030 Macro ADC_AVG4_EN defined: each sample SHALL run 4 back-to-back frames, sum codes in 14 bits, adc_code = sum>>2 (truncate); the REQ-025 latency applies from the 4th frame's cs_n rising.
REQ-031 Macro ADC_AVG4_EN undefined: one frame per sample and no accumulator logic.

Verification
REQ-032 ref_code=2048, ADC model returns 1024 -> e0=64'h4090000000000000, adc_code=1024, e0ready high exactly 4 cycles.
REQ-033 ref_code=1000, ADC returns 1000 -> e0=64'h0000000000000000; e0ready still pulses.
REQ-034 ref_code=0, ADC returns 4095 -> e0=64'hC0AFFE0000000000.
REQ-035 Default parameters, CHANNEL=3'd5 -> 16 SCLK pulses per frame; adc_din shows 1,0,1 on clocks 3-5; e0ready rising edges exactly 400 cycles apart.
REQ-036 iRST pulsed at SCLK pulse 8 -> cs_n=1 and e0=0 without waiting for a clock edge; clean full frame restarts after release.
REQ-037 SAMPLE_PERIOD=50 -> overrun=1; no overlapping frames; e0ready period 100 cycles.
